iobus_prng: RTL and testbench

IOBUS_PRNG -- requirements
Module: iobus_prng

---
 rtl/iobus_prng.sv | 218 +++++++++++++++++++++
 tb/tb_iobus_prng.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/iobus_prng.sv
// -----------------------------------------------------------------------------
// iobus_prng
//
// Purpose:
//   Memory-mapped xorshift32 pseudo-random number generator on the IO bus.
//   One decoded window of ADDRESS_STRIDE bytes starting at BASE_ADDRESS.
//   Every decoded access (hit) completes with a single io_ready pulse one
//   cycle after io_addr_strobe; misses are ignored completely.
//
//   Register map (word offset = io_address[11:2]):
//     0x0 SEED  RW  read: current generator state
//                   write: byte-merged into the state, zero result loads 1
//     0x4 RAND  RO  read: state <= xorshift32(state), returns the new state
//     0x8 COUNT RW  number of RAND reads (wrapping), any write clears it
//                   (present only when IOBUS_PRNG_COUNT_EN is defined)
//   Undefined offsets (and writes to RAND) are acknowledged, have no effect
//   and read as 0.
//
// Build option:
//   IOBUS_PRNG_COUNT_EN  define to include the COUNT register.
//
// Ports:
//   io_clk           in   clock, rising edge
//   io_rst_n         in   asynchronous active-low reset
//   io_addr_strobe   in   one-cycle transaction start
//   io_read_strobe   in   read qualifier
//   io_write_strobe  in   write qualifier (wins over read)
//   io_address       in   32-bit byte address
//   io_byte_enable   in   write byte lanes, bit n -> bits 8n+7:8n
//   io_write_data    in   32-bit write data
//   io_read_data     out  32-bit read data, 0 outside a read response
//   io_ready         out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module iobus_prng #(
    parameter logic [31:0] BASE_ADDRESS   = 32'hC0002000,
    parameter logic [31:0] ADDRESS_STRIDE = 32'h1000
) (
    input  logic        io_clk,
    input  logic        io_rst_n,
    input  logic        io_addr_strobe,
    input  logic        io_read_strobe,
    input  logic        io_write_strobe,
    input  logic [31:0] io_address,
    input  logic [3:0]  io_byte_enable,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        io_ready
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    localparam logic [9:0] OFS_SEED  = 10'd0;
    localparam logic [9:0] OFS_RAND  = 10'd1;
    localparam logic [9:0] OFS_COUNT = 10'd2;

    // Window end computed one bit wider so a window touching the top of the
    // address space does not wrap to zero.
    localparam logic [32:0] WIN_BASE = {1'b0, BASE_ADDRESS};
    localparam logic [32:0] WIN_END  = {1'b0, BASE_ADDRESS} + {1'b0, ADDRESS_STRIDE};

    localparam logic [31:0] STATE_RESET = 32'h0000_0001;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------
    function automatic logic [31:0] xorshift32(input logic [31:0] x_in);
        logic [31:0] x;
        x = x_in;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return m;
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [0:0]  r_fsm;
    logic        r_ready;
    logic [31:0] r_read_data;
    logic [31:0] r_state;
`ifdef IOBUS_PRNG_COUNT_EN
    logic [31:0] r_count;
`endif

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    logic        w_in_window;
    logic        w_hit;
    logic        w_accept;
    logic        w_wr;
    logic        w_rd;
    logic [9:0]  w_offset;

    assign w_in_window = ({1'b0, io_address} >= WIN_BASE) &&
                         ({1'b0, io_address} <  WIN_END);
    assign w_hit       = io_addr_strobe && w_in_window;
    // Strobes arriving while the response is still being presented are dropped.
    assign w_accept    = w_hit && (r_fsm == ST_IDLE);
    assign w_wr        = io_write_strobe;
    assign w_rd        = io_read_strobe && !io_write_strobe;
    assign w_offset    = io_address[11:2];

    // -------------------------------------------------------------------------
    // Next-state and read mux
    // -------------------------------------------------------------------------
    logic [31:0] w_rand_next;
    logic [31:0] w_seed_merged;
    logic [31:0] w_state_next;
    logic [31:0] w_rdata;
`ifdef IOBUS_PRNG_COUNT_EN
    logic [31:0] w_count_next;
`endif

    assign w_rand_next   = xorshift32(r_state);
    assign w_seed_merged = merge_bytes(r_state, io_write_data, io_byte_enable);

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            if (w_wr && (w_offset == OFS_SEED)) begin
                // An all-zero state would lock xorshift at zero forever.
                w_state_next = (w_seed_merged == 32'h0) ? STATE_RESET : w_seed_merged;
            end else if (w_rd && (w_offset == OFS_RAND)) begin
                w_state_next = w_rand_next;
            end
        end
    end

`ifdef IOBUS_PRNG_COUNT_EN
    always_comb begin
        w_count_next = r_count;
        if (w_accept && w_wr && (w_offset == OFS_COUNT)) begin
            w_count_next = 32'h0;
        end else if (w_accept && w_rd && (w_offset == OFS_RAND)) begin
            w_count_next = r_count + 32'd1;
        end
    end
`endif

    always_comb begin
        w_rdata = 32'h0;
        if (w_rd) begin
            case (w_offset)
                OFS_SEED:  w_rdata = r_state;
                OFS_RAND:  w_rdata = w_rand_next;
`ifdef IOBUS_PRNG_COUNT_EN
                OFS_COUNT: w_rdata = r_count;
`endif
                default:   w_rdata = 32'h0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sequential: FSM, response and register state
    // -------------------------------------------------------------------------
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            r_fsm       <= ST_IDLE;
            r_ready     <= 1'b0;
            r_read_data <= 32'h0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_fsm       <= ST_RESP;
                        r_ready     <= 1'b1;
                        r_read_data <= w_rdata;
                    end else begin
                        r_ready     <= 1'b0;
                        r_read_data <= 32'h0;
                    end
                end
                default: begin
                    // Response lasts exactly one cycle; bus returns to 0.
                    r_fsm       <= ST_IDLE;
                    r_ready     <= 1'b0;
                    r_read_data <= 32'h0;
                end
            endcase
        end
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            r_state <= STATE_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef IOBUS_PRNG_COUNT_EN
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            r_count <= 32'h0;
        end else begin
            r_count <= w_count_next;
        end
    end
`endif

    assign io_ready     = r_ready;
    assign io_read_data = r_read_data;

endmodule

// File: tb/tb_iobus_prng.sv
module tb_iobus_prng;

    logic        io_clk;
    logic        io_rst_n;
    logic        io_addr_strobe;
    logic        io_read_strobe;
    logic        io_write_strobe;
    logic [31:0] io_address;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;
    logic        io_ready;

    int n_checks = 0;
    int n_pass   = 0;

    iobus_prng dut (
        .io_clk          (io_clk),
        .io_rst_n        (io_rst_n),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_address      (io_address),
        .io_byte_enable  (io_byte_enable),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<500000", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        exp_rdy;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    function automatic logic [31:0] ref_xorshift(input logic [31:0] x_in);
        logic [31:0] x;
        x = x_in;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive_idle();
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_byte_enable  = 4'h0;
        io_write_data   = 32'h0;
    endtask

    // One transaction: strobe for one cycle, check the response cycle and
    // that the bus is quiet in the following cycle.
    task automatic txn(input string name, input logic [31:0] addr, input logic rd,
                       input logic wr, input logic [3:0] be, input logic [31:0] wd,
                       input logic exp_rdy, input logic [31:0] exp_data);
        @(negedge io_clk);
        io_addr_strobe  = 1'b1;
        io_read_strobe  = rd;
        io_write_strobe = wr;
        io_address      = addr;
        io_byte_enable  = be;
        io_write_data   = wd;
        @(posedge io_clk);
        #1;
        drive_idle();
        check({name, " ready"}, {31'h0, io_ready}, {31'h0, exp_rdy});
        check({name, " data"}, io_read_data, exp_data);
        @(posedge io_clk);
        #1;
        check({name, " ready after"}, {31'h0, io_ready}, 32'h0);
        check({name, " data after"}, io_read_data, 32'h0);
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] v;

        vecs[0]  = '{32'hC0002004, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h00042021};
        vecs[1]  = '{32'hC0002004, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h04080601};
        vecs[2]  = '{32'hC0002000, 1'b0, 1'b1, 4'hF, 32'h00000000, 1'b1, 32'h0};
        vecs[3]  = '{32'hC0002000, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h00000001};
        vecs[4]  = '{32'hC0002000, 1'b0, 1'b1, 4'b0001, 32'hAABBCCDD, 1'b1, 32'h0};
        vecs[5]  = '{32'hC0002000, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h000000DD};
        vecs[6]  = '{32'hC0003000, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0};
        vecs[7]  = '{32'hC0002FFC, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h0};
        vecs[8]  = '{32'hC0001FFC, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0};
        vecs[9]  = '{32'hC0002004, 1'b0, 1'b1, 4'hF, 32'h12345678, 1'b1, 32'h0};
        vecs[10] = '{32'hC0002000, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h000000DD};
        vecs[11] = '{32'hC0002000, 1'b0, 1'b1, 4'b1010, 32'h11223344, 1'b1, 32'h0};
        vecs[12] = '{32'hC0002000, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h110033DD};
        vecs[13] = '{32'hC0002000, 1'b1, 1'b1, 4'hF, 32'h00000005, 1'b1, 32'h0};
        vecs[14] = '{32'hC0002000, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h00000005};

        io_rst_n   = 1'b0;
        io_address = 32'h0;
        drive_idle();
        #1;
        check("reset ready", {31'h0, io_ready}, 32'h0);
        check("reset data", io_read_data, 32'h0);
        repeat (2) @(posedge io_clk);
        @(negedge io_clk);
        io_rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rd, vecs[i].wr,
                vecs[i].be, vecs[i].wd, vecs[i].exp_rdy, vecs[i].exp_data);
        end

        // Idle cycles: bus stays 0 and the state does not advance.
        repeat (5) begin
            @(posedge io_clk);
            #1;
            check("idle data", io_read_data, 32'h0);
        end
        txn("seed after idle", 32'hC0002000, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 32'h00000005);

        // Strobe held into RESP: the second strobe is ignored.
        s = ref_xorshift(32'h00000005);
        @(negedge io_clk);
        io_addr_strobe = 1'b1;
        io_read_strobe = 1'b1;
        io_address     = 32'hC0002004;
        @(posedge io_clk);
        #1;
        check("held ready1", {31'h0, io_ready}, 32'h1);
        check("held data1", io_read_data, s);
        @(posedge io_clk);
        #1;
        drive_idle();
        check("held ready2", {31'h0, io_ready}, 32'h0);
        check("held data2", io_read_data, 32'h0);
        txn("held seed", 32'hC0002000, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1, s);

`ifdef IOBUS_PRNG_COUNT_EN
        txn("cnt seed", 32'hC0002000, 1'b0, 1'b1, 4'hF, 32'h00000001, 1'b1, 32'h0);
        txn("cnt clr0", 32'hC0002008, 1'b0, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0);
        v = 32'h00000001;
        for (int k = 0; k < 3; k++) begin
            v = ref_xorshift(v);
            txn($sformatf("cnt rand%0d", k), 32'hC0002004, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1, v);
        end
        txn("cnt read3", 32'hC0002008, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 32'h00000003);
        txn("cnt clr", 32'hC0002008, 1'b0, 1'b1, 4'h0, 32'h0, 1'b1, 32'h0);
        txn("cnt read0", 32'hC0002008, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 32'h00000000);
`else
        v = 32'h0;
        txn("ofs8 read", 32'hC0002008, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1, v);
`endif

        // Reset asserted mid-cycle during the RESP of a RAND read.
        @(negedge io_clk);
        io_addr_strobe = 1'b1;
        io_read_strobe = 1'b1;
        io_address     = 32'hC0002004;
        @(posedge io_clk);
        #1;
        drive_idle();
        check("rst ready before", {31'h0, io_ready}, 32'h1);
        #2;
        io_rst_n = 1'b0;
        #1;
        check("rst ready drop", {31'h0, io_ready}, 32'h0);
        check("rst data drop", io_read_data, 32'h0);
        @(negedge io_clk);
        io_rst_n = 1'b1;
        txn("post-rst rand", 32'hC0002004, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 32'h00042021);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
